// File: rtl/ram8_pkg.sv
// Shared widths, types and reset constant for the eight-word register bank.
package ram8_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam word_t WORD_RESET = 16'h0000;

endpackage

// File: rtl/mux8way16.sv
// 8-way 16-bit word multiplexer: out is the word picked by sel.
module mux8way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/ram8_register16.sv
// register16: one 16-bit word with synchronous clear (priority) and load enable.
module register16
    import ram8_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  word_t in,
    input  logic  load,
    output word_t out
);

    always_ff @(posedge clock) begin
        if (reset)
            out <= WORD_RESET;
        else if (load)
            out <= in;
    end

endmodule

// File: rtl/ram8.sv
// ram8: 8 x 16 register bank, synchronous write, combinational read.
// Optional RAM8_WRITE_THROUGH_EN forwards `in` to `out` while load is high.
module ram8
    import ram8_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  word_t in,
    input  logic  load,
    input  addr_t address,
    output word_t out
);

    logic [DEPTH-1:0]             word_en;
    logic [DEPTH-1:0][WORD_W-1:0] words;
    word_t                        mux_out;

    // One-hot write enables; all zero when load is low.
    always_comb begin
        word_en = '0;
        if (load)
            word_en[address] = 1'b1;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register16 u_reg (
            .clock (clock),
            .reset (reset),
            .in    (in),
            .load  (word_en[i]),
            .out   (words[i])
        );
    end

    mux8way16 u_mux (
        .a   (words[0]),
        .b   (words[1]),
        .c   (words[2]),
        .d   (words[3]),
        .e   (words[4]),
        .f   (words[5]),
        .g   (words[6]),
        .h   (words[7]),
        .sel (address),
        .out (mux_out)
    );

`ifdef RAM8_WRITE_THROUGH_EN
    // Forwarding is suppressed during reset so out tracks the storage mux.
    assign out = (load && !reset) ? in : mux_out;
`else
    assign out = mux_out;
`endif

endmodule

// File: tb/tb_ram8.sv
// Directed self-checking bench for ram8 (both builds of RAM8_WRITE_THROUGH_EN).
module tb_ram8;

    logic        clock;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] pat [8];

    ram8 dut (
        .clock   (clock),
        .reset   (reset),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs then change away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
        address = a;
        #1;
        chk(tag, out, exp);
    endtask

    initial begin
        pat[0] = 16'b0101010101010101;
        pat[1] = 16'b1010101010101010;
        pat[2] = 16'b0000000011111111;
        pat[3] = 16'b1111111100000000;
        pat[4] = 16'b0011001100110011;
        pat[5] = 16'b1100110011001100;
        pat[6] = 16'b0000111100001111;
        pat[7] = 16'b1111000011110000;

        reset = 1'b1; load = 1'b0; in = 16'h0; address = 3'd0;
        #2;
        tick();
        reset = 1'b0;

        // 1: all words cleared
        for (int i = 0; i < 8; i++) rd($sformatf("reset_a%0d", i), 3'(i), 16'h0000);

        // 2: pattern write, then full readback
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), pat[i]);
            rd($sformatf("wr_imm_a%0d", i), 3'(i), pat[i]);
            if (i < 7) rd($sformatf("wr_next_a%0d", i + 1), 3'(i + 1), 16'h0000);
        end
        for (int i = 0; i < 8; i++) rd($sformatf("readback_a%0d", i), 3'(i), pat[i]);

        // 3: hold with in = FFFF
        wr(3'd3, 16'hAAAA);
        in = 16'hFFFF; load = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rd("hold_a3", 3'd3, 16'hAAAA);
        rd("hold_a2", 3'd2, pat[2]);
        rd("hold_a4", 3'd4, pat[4]);

        // 4: read-during-write at address 5
        wr(3'd5, 16'h1234);
        address = 3'd5; in = 16'hBEEF; load = 1'b1;
        #1;
`ifdef RAM8_WRITE_THROUGH_EN
        chk("rdw_before", out, 16'hBEEF);
`else
        chk("rdw_before", out, 16'h1234);
`endif
        tick();
        load = 1'b0; in = 16'h0;
        rd("rdw_after", 3'd5, 16'hBEEF);
        rd("rdw_a4", 3'd4, pat[4]);

        // 5: reset wins over a simultaneous write
        reset = 1'b1; load = 1'b1; in = 16'h5555; address = 3'd2;
        #1;
        chk("rst_before_a2", out, pat[2]);
        tick();
        reset = 1'b0; load = 1'b0;
        for (int i = 0; i < 8; i++) rd($sformatf("rst_clr_a%0d", i), 3'(i), 16'h0000);
        wr(3'd2, 16'h5555);
        rd("post_rst_wr_a2", 3'd2, 16'h5555);
        rd("post_rst_a1", 3'd1, 16'h0000);

        // 6: back-to-back writes to address 7
        address = 3'd7; in = 16'h0001; load = 1'b1;
        tick();
        load = 1'b0;
        #1;
        chk("b2b_first", out, 16'h0001);
        in = 16'h0002; load = 1'b1;
        tick();
        load = 1'b0;
        #1;
        chk("b2b_second", out, 16'h0002);
        rd("b2b_a2", 3'd2, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
